pipe_hazard_ctrl: RTL and testbench

//  Sequences the IF/ID and ID/EX pipeline registers of the RV32I core: write-enable (stall), flush and bubble control.

---
 rtl/rv32i_pipe_pkg.sv | 23 ++
 rtl/pipe_hazard_ctrl_if.sv | 35 +++
 rtl/hazard_detect.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/rv32i_pipe_pkg.sv
// Shared encodings for the RV32I pipeline hazard controller:
// memtoreg codes, hazard FSM states and a saturating counter helper.
package rv32i_pipe_pkg;

   typedef logic [1:0] mtr_t;

   localparam mtr_t MTR_ALU = 2'd0;
   localparam mtr_t MTR_MEM = 2'd1;
   localparam mtr_t MTR_PC4 = 2'd2;

   localparam logic [4:0] REG_X0 = 5'd0;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      WAIT  = 2'd2
   } hz_state_t;

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic [15:0] lim);
      return (v >= lim) ? lim : v + 16'd1;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline <-> hazard controller bundle: ID/EX hazard inputs, memory busy
// and the stage enable/flush/bubble controls returned to the pipeline.
interface pipe_hazard_ctrl_if;

   logic [4:0]          id_rs1;
   logic [4:0]          id_rs2;
   logic                id_use_rs1;
   logic                id_use_rs2;
   logic [4:0]          ex_rd;
   logic                ex_regwrite;
   rv32i_pipe_pkg::mtr_t ex_memtoreg;
   logic                ex_redirect;
   logic                mem_busy;

   logic                pc_we;
   logic                if_id_we;
   logic                if_id_flush;
   logic                id_ex_we;
   logic                id_ex_bubble;

   // Pipeline datapath side
   modport master (
      output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
      output ex_rd, ex_regwrite, ex_memtoreg, ex_redirect, mem_busy,
      input  pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble
   );

   // Hazard controller side
   modport slave (
      input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
      input  ex_rd, ex_regwrite, ex_memtoreg, ex_redirect, mem_busy,
      output pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble
   );

endinterface

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose rd (not x0) is read
// by the instruction currently in ID.
module hazard_detect
   import rv32i_pipe_pkg::*;
(
   input  logic [4:0] id_rs1_i,
   input  logic [4:0] id_rs2_i,
   input  logic       id_use_rs1_i,
   input  logic       id_use_rs2_i,
   input  logic [4:0] ex_rd_i,
   input  logic       ex_regwrite_i,
   input  mtr_t       ex_memtoreg_i,
   output logic       load_use_o
);

   logic ex_is_load;
   logic rs1_hit;
   logic rs2_hit;

   assign ex_is_load = ex_regwrite_i && (ex_memtoreg_i == MTR_MEM) && (ex_rd_i != REG_X0);
   assign rs1_hit    = id_use_rs1_i && (id_rs1_i == ex_rd_i);
   assign rs2_hit    = id_use_rs2_i && (id_rs2_i == ex_rd_i);
   assign load_use_o = ex_is_load && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/bubble sequencer for the PC, IF/ID and ID/EX registers.
// Optional HAZARD_PERF_EN adds stall/flush/wait cycle counters.
module pipe_hazard_ctrl
   import rv32i_pipe_pkg::*;
#(
   parameter int MEM_TIMEOUT    = 255,
   parameter int BRANCH_PENALTY = 1
) (
   input  logic              clk,
   input  logic              rst,
   pipe_hazard_ctrl_if.slave hz,
`ifdef HAZARD_PERF_EN
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_cycles,
   output logic [31:0]       wait_cycles,
`endif
   output logic              err_timeout
);

   localparam logic [15:0] WAIT_LIM   = 16'(MEM_TIMEOUT);
   localparam logic [1:0]  FLUSH_LOAD = 2'(BRANCH_PENALTY - 1);

   hz_state_t   state_q, state_d;
   logic [1:0]  flush_cnt_q, flush_cnt_d;
   logic [15:0] wait_cnt_q, wait_cnt_d;
   logic        pend_redir_q, pend_redir_d;
   logic        err_q, err_d;

   logic load_use;
   logic redirect_eff;
   logic at_limit;
   logic pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble;

   hazard_detect u_detect (
      .id_rs1_i      (hz.id_rs1),
      .id_rs2_i      (hz.id_rs2),
      .id_use_rs1_i  (hz.id_use_rs1),
      .id_use_rs2_i  (hz.id_use_rs2),
      .ex_rd_i       (hz.ex_rd),
      .ex_regwrite_i (hz.ex_regwrite),
      .ex_memtoreg_i (hz.ex_memtoreg),
      .load_use_o    (load_use)
   );

   assign at_limit     = (wait_cnt_q == WAIT_LIM);
   // A redirect captured while frozen replays in the WAIT exit cycle.
   assign redirect_eff = hz.ex_redirect || ((state_q == WAIT) && pend_redir_q);

   always_comb begin
      // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latches).
      state_d      = state_q;
      flush_cnt_d  = flush_cnt_q;
      wait_cnt_d   = wait_cnt_q;
      pend_redir_d = pend_redir_q;
      err_d        = err_q;
      pc_we        = 1'b1;
      if_id_we     = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_we     = 1'b1;
      id_ex_bubble = 1'b0;

      if (rst) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (hz.mem_busy) begin
         pc_we    = 1'b0;
         if_id_we = 1'b0;
         id_ex_we = 1'b0;
         if (state_q == RUN) begin
            state_d      = WAIT;
            wait_cnt_d   = 16'd1;
            pend_redir_d = hz.ex_redirect;
         end else begin
            // FLUSH freezes in place so its remaining count survives the stall.
            wait_cnt_d = sat_inc(wait_cnt_q, WAIT_LIM);
            if (at_limit) err_d = 1'b1;
            if (state_q == WAIT) pend_redir_d = pend_redir_q || hz.ex_redirect;
         end
      end else if (state_q == FLUSH) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
         wait_cnt_d   = 16'd0;
         flush_cnt_d  = flush_cnt_q - 2'd1;
         if (flush_cnt_q <= 2'd1) state_d = RUN;
      end else begin
         state_d      = RUN;
         pend_redir_d = 1'b0;
         if (redirect_eff) begin
            // Redirect squashes the ID instruction, so a coincident load-use stall is dropped.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (BRANCH_PENALTY > 1) begin
               state_d     = FLUSH;
               flush_cnt_d = FLUSH_LOAD;
               wait_cnt_d  = 16'd0;
            end
         end else if (load_use) begin
            pc_we        = 1'b0;
            if_id_we     = 1'b0;
            id_ex_bubble = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= RUN;
         flush_cnt_q  <= 2'd0;
         wait_cnt_q   <= 16'd0;
         pend_redir_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_cnt_q  <= flush_cnt_d;
         wait_cnt_q   <= wait_cnt_d;
         pend_redir_q <= pend_redir_d;
         err_q        <= err_d;
      end
   end

   assign hz.pc_we        = pc_we;
   assign hz.if_id_we     = if_id_we;
   assign hz.if_id_flush  = if_id_flush;
   assign hz.id_ex_we     = id_ex_we;
   assign hz.id_ex_bubble = id_ex_bubble;
   assign err_timeout     = err_q;

`ifdef HAZARD_PERF_EN
   logic [31:0] stall_q, flush_q, wait_q;
   logic        stall_act;

   assign stall_act = !rst && !pc_we && if_id_we == 1'b0 && id_ex_we && id_ex_bubble;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= 32'd0;
         flush_q <= 32'd0;
         wait_q  <= 32'd0;
      end else begin
         if (stall_act)         stall_q <= stall_q + 32'd1;
         if (if_id_flush)       flush_q <= flush_q + 32'd1;
         if (state_q == WAIT)   wait_q  <= wait_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_cycles = flush_q;
   assign wait_cycles  = wait_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (BRANCH_PENALTY=2, MEM_TIMEOUT=8):
// a cycle-by-cycle vector table plus a hand-written timeout sequence.
module tb_pipe_hazard_ctrl;
   import rv32i_pipe_pkg::*;

   // Expected output word: {pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_bubble, err_timeout}
   localparam logic [5:0] E_RST    = 6'b001110;
   localparam logic [5:0] E_RUN    = 6'b110100;
   localparam logic [5:0] E_STALL  = 6'b000110;
   localparam logic [5:0] E_FLUSH  = 6'b111110;
   localparam logic [5:0] E_FREEZE = 6'b000000;

   typedef struct {
      string      name;
      logic       rst;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       use1;
      logic       use2;
      logic [4:0] rd;
      logic       rw;
      mtr_t       mtr;
      logic       redir;
      logic       busy;
      logic [5:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   logic err_timeout;
`ifdef HAZARD_PERF_EN
   logic [31:0] stall_cycles, flush_cycles, wait_cycles;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   vec_t vecs[$];

   pipe_hazard_ctrl_if hz ();

   pipe_hazard_ctrl #(
      .MEM_TIMEOUT    (8),
      .BRANCH_PENALTY (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .hz           (hz),
`ifdef HAZARD_PERF_EN
      .stall_cycles (stall_cycles),
      .flush_cycles (flush_cycles),
      .wait_cycles  (wait_cycles),
`endif
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   function automatic void add(input string nm, input logic r, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u1, input logic u2,
                               input logic [4:0] rd, input logic rw, input mtr_t mtr,
                               input logic redir, input logic busy, input logic [5:0] e);
      vec_t v;
      v.name = nm; v.rst = r; v.rs1 = rs1; v.rs2 = rs2; v.use1 = u1; v.use2 = u2;
      v.rd = rd; v.rw = rw; v.mtr = mtr; v.redir = redir; v.busy = busy; v.exp = e;
      vecs.push_back(v);
   endfunction

   // Idle cycle: no load in EX, no redirect, memory ready.
   function automatic void idle(input string nm, input logic r, input logic redir,
                                input logic busy, input logic [5:0] e);
      add(nm, r, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, MTR_ALU, redir, busy, e);
   endfunction

   task automatic drive(input vec_t v);
      rst            = v.rst;
      hz.id_rs1      = v.rs1;
      hz.id_rs2      = v.rs2;
      hz.id_use_rs1  = v.use1;
      hz.id_use_rs2  = v.use2;
      hz.ex_rd       = v.rd;
      hz.ex_regwrite = v.rw;
      hz.ex_memtoreg = v.mtr;
      hz.ex_redirect = v.redir;
      hz.mem_busy    = v.busy;
   endtask

   task automatic check(input string nm, input logic [5:0] exp);
      logic [5:0] got;
      got = {hz.pc_we, hz.if_id_we, hz.if_id_flush, hz.id_ex_we, hz.id_ex_bubble, err_timeout};
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got pc/ifid/flush/idex/bubble/err=%b want %b", nm, got, exp);
      end
   endtask

   // Drive just after the rising edge, compare mid-cycle on the falling edge.
   task automatic run_cycle(input vec_t v);
      @(posedge clk);
      #1;
      drive(v);
      @(negedge clk);
      check(v.name, v.exp);
   endtask

   initial begin
      vec_t v;

      idle("rst_c1", 1'b1, 1'b0, 1'b0, E_RST);
      idle("rst_c2", 1'b1, 1'b0, 1'b0, E_RST);
      idle("run_after_rst", 1'b0, 1'b0, 1'b0, E_RUN);
      add("load_use_rs2", 1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, MTR_MEM, 1'b0, 1'b0, E_STALL);
      add("bubble_in_ex", 1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, MTR_ALU, 1'b0, 1'b0, E_RUN);
      add("load_rd_x0",   1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, MTR_MEM, 1'b0, 1'b0, E_RUN);
      add("load_rd_unread", 1'b0, 5'd3, 5'd4, 1'b1, 1'b1, 5'd7, 1'b1, MTR_MEM, 1'b0, 1'b0, E_RUN);
      add("rs2_match_unused", 1'b0, 5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, MTR_MEM, 1'b0, 1'b0, E_RUN);
      add("alu_not_load", 1'b0, 5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, MTR_ALU, 1'b0, 1'b0, E_RUN);
      add("load_no_regwr", 1'b0, 5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b0, MTR_MEM, 1'b0, 1'b0, E_RUN);
      add("load_use_rs1", 1'b0, 5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, MTR_MEM, 1'b0, 1'b0, E_STALL);
      idle("redirect_c1", 1'b0, 1'b1, 1'b0, E_FLUSH);
      idle("redirect_c2", 1'b0, 1'b0, 1'b0, E_FLUSH);
      idle("after_flush", 1'b0, 1'b0, 1'b0, E_RUN);
      add("redir_and_lu", 1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, MTR_MEM, 1'b1, 1'b0, E_FLUSH);
      add("redir_lu_c2",  1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, MTR_MEM, 1'b0, 1'b0, E_FLUSH);
      idle("redir_lu_done", 1'b0, 1'b0, 1'b0, E_RUN);
      idle("busy_c1", 1'b0, 1'b0, 1'b1, E_FREEZE);
      idle("busy_c2_redir", 1'b0, 1'b1, 1'b1, E_FREEZE);
      idle("busy_c3", 1'b0, 1'b0, 1'b1, E_FREEZE);
      idle("busy_c4", 1'b0, 1'b0, 1'b1, E_FREEZE);
      idle("wait_exit_flush", 1'b0, 1'b0, 1'b0, E_FLUSH);
      idle("wait_exit_flush2", 1'b0, 1'b0, 1'b0, E_FLUSH);
      idle("after_wait", 1'b0, 1'b0, 1'b0, E_RUN);
      idle("busy_plain", 1'b0, 1'b0, 1'b1, E_FREEZE);
      add("exit_load_use", 1'b0, 5'd1, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, MTR_MEM, 1'b0, 1'b0, E_STALL);
      idle("exit_lu_clear", 1'b0, 1'b0, 1'b0, E_RUN);
      idle("flush_then_busy", 1'b0, 1'b1, 1'b0, E_FLUSH);
      idle("busy_in_flush", 1'b0, 1'b0, 1'b1, E_FREEZE);
      idle("flush_resumes", 1'b0, 1'b0, 1'b0, E_FLUSH);
      idle("flush_resumed_done", 1'b0, 1'b0, 1'b0, E_RUN);
      idle("rst_over_busy", 1'b1, 1'b1, 1'b1, E_RST);
      idle("run_after_rst2", 1'b0, 1'b0, 1'b0, E_RUN);

      foreach (vecs[i]) run_cycle(vecs[i]);

      // Timeout: 20 busy cycles; err_timeout is set at the end of busy cycle 9.
      for (int k = 1; k <= 20; k++) begin
         v = vecs[0];
         v.rst  = 1'b0;
         v.busy = 1'b1;
         v.name = $sformatf("timeout_busy_%0d", k);
         v.exp  = {5'b00000, (k >= 10) ? 1'b1 : 1'b0};
         run_cycle(v);
      end
      for (int k = 1; k <= 3; k++) begin
         v = vecs[0];
         v.rst  = 1'b0;
         v.busy = 1'b0;
         v.name = $sformatf("err_sticky_%0d", k);
         v.exp  = {E_RUN[5:1], 1'b1};
         run_cycle(v);
      end

      // Reset clears the sticky error once it has been sampled.
      @(posedge clk);
      #1;
      v = vecs[0];
      drive(v);
      v.name = "err_cleared_by_rst";
      run_cycle(v);
      v = vecs[2];
      v.name = "run_after_err_clear";
      run_cycle(v);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
